vga_timing_gen: RTL and testbench

Parametrised VGA timing generator; successor to the fixed 640x480 vga_controller. Divides the system clock to a pixel tick, runs horizontal/vertical counters, and produces sync, blanking and pixel coordinates. Adds configurable resolution and porches, selectable sync polarity, a run enable, line/frame start strobes and a frame counter. Feeds the pixel-generation and sprite logic downstream.

---
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, h/v counters, registered
// sync/blanking decode, line/frame start strobes and a wrapping frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          enable,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic          p_tick_q, p_tick_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          advance;

  // Decode is done on the next-state coordinates so every registered output
  // lines up with x/y in the same cycle.
  always_comb begin
    div_d         = div_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_count_d = frame_count_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    p_tick_d      = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    advance       = enable && (div_q == DIV_MAX);

    if (enable) begin
      div_d    = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      p_tick_d = (div_d == DIV_MAX);
    end

    if (advance) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      line_start_d  = (x_d == '0);
      frame_start_d = (x_d == '0) && (y_d == '0);
      if (frame_start_d) begin
        frame_count_d = frame_count_q + 8'd1;
      end
      hsync_d    = (x_d >= HS_START && x_d <= HS_END) ? HS_POL : ~HS_POL;
      vsync_d    = (y_d >= VS_START && y_d <= VS_END) ? VS_POL : ~VS_POL;
      video_on_d = (x_d < X_ACT) && (y_d < Y_ACT);
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      div_q         <= '0;
      p_tick_q      <= 1'b0;
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      video_on_q    <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      div_q         <= div_d;
      p_tick_q      <= p_tick_d;
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign p_tick      = p_tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small raster: an arithmetic model
// derived from the count of enabled clocks, directed literal checks, random enable/reset.
module tb_vga_timing_gen;

  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam bit HS_POL   = 1'b1;
  localparam bit VS_POL   = 1'b0;
  localparam int CW       = 6;
  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = HT * VT;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          pTick, hsync, vsync, videoOn, lineStart, frameStart;
  logic [CW-1:0] x, y;
  logic [7:0]    frameCount;

  int checks = 0;
  int errors = 0;

  // Model state: enabled edges since the last reset, and whether the last edge was enabled.
  int  nEdges = 0;
  bit  lastEn = 1'b0;
  bit  rstSeen = 1'b0;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .enable     (enable),
    .p_tick     (pTick),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (videoOn),
    .x          (x),
    .y          (y),
    .line_start (lineStart),
    .frame_start(frameStart),
    .frame_count(frameCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en);
    reset  = rst;
    enable = en;
    @(negedge clk);
  endtask

  // Runs with enable high until (x,y) shows the target; wy < 0 means any line.
  task automatic waitFor(input int wx, input int wy, input int limit, input string name);
    int k;
    k = 0;
    while (!(int'(x) == wx && (wy < 0 || int'(y) == wy)) && k < limit) begin
      applyStimulus(1'b0, 1'b1);
      k++;
    end
    checkOutput(name, int'(k < limit), 1);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      nEdges  = 0;
      lastEn  = 1'b0;
      rstSeen = 1'b1;
    end else if (enable) begin
      nEdges++;
      lastEn = 1'b1;
    end else begin
      lastEn = 1'b0;
    end
  end

  // Every tick is CLK_DIV enabled edges; the raster position is the tick count
  // minus one, modulo the frame, with tick zero meaning the last pixel.
  always @(negedge clk) begin
    if (rstSeen) begin
      int t, lin, ex, ey, efc;
      bit adv, eTick;
      t     = nEdges / CLK_DIV;
      lin   = (t == 0) ? FRAME - 1 : (t - 1) % FRAME;
      ex    = lin % HT;
      ey    = lin / HT;
      efc   = (t == 0) ? 0 : (((t - 1) / FRAME) + 1) % 256;
      eTick = lastEn && (nEdges % CLK_DIV == CLK_DIV - 1);
      adv   = lastEn && (nEdges > 0) && (nEdges % CLK_DIV == 0);
      checkOutput("x", int'(x), ex);
      checkOutput("y", int'(y), ey);
      checkOutput("p_tick", int'(pTick), int'(eTick));
      checkOutput("video_on", int'(videoOn), int'(ex < H_ACTIVE && ey < V_ACTIVE));
      checkOutput("hsync", int'(hsync),
                  (ex >= H_ACTIVE + H_FP && ex < H_ACTIVE + H_FP + H_SYNC) ? int'(HS_POL) : int'(!HS_POL));
      checkOutput("vsync", int'(vsync),
                  (ey >= V_ACTIVE + V_FP && ey < V_ACTIVE + V_FP + V_SYNC) ? int'(VS_POL) : int'(!VS_POL));
      checkOutput("line_start", int'(lineStart), int'(adv && ex == 0));
      checkOutput("frame_start", int'(frameStart), int'(adv && lin == 0));
      checkOutput("frame_count", int'(frameCount), efc);
    end
  end

  initial begin
    @(negedge clk);
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("rst_x", int'(x), 13);
    checkOutput("rst_y", int'(y), 6);
    checkOutput("rst_hsync", int'(hsync), 0);
    checkOutput("rst_vsync", int'(vsync), 1);
    checkOutput("rst_video_on", int'(videoOn), 0);
    checkOutput("rst_frame_count", int'(frameCount), 0);

    applyStimulus(1'b0, 1'b1);
    checkOutput("first_tick", int'(pTick), 1);
    checkOutput("first_tick_x", int'(x), 13);
    applyStimulus(1'b0, 1'b1);
    checkOutput("origin_x", int'(x), 0);
    checkOutput("origin_y", int'(y), 0);
    checkOutput("origin_frame_start", int'(frameStart), 1);
    checkOutput("origin_line_start", int'(lineStart), 1);
    checkOutput("origin_frame_count", int'(frameCount), 1);
    checkOutput("origin_video_on", int'(videoOn), 1);

    waitFor(10, 0, 100, "reach_x10");
    checkOutput("hsync_at_x10", int'(hsync), 1);
    checkOutput("video_off_x10", int'(videoOn), 0);

    waitFor(3, -1, 100, "reach_x3");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("hold_x", int'(x), 3);
      checkOutput("hold_p_tick", int'(pTick), 0);
      checkOutput("hold_line_start", int'(lineStart), 0);
    end

    waitFor(5, 2, 500, "reach_x5_y2");
    applyStimulus(1'b1, 1'b1);
    checkOutput("midrst_x", int'(x), 13);
    checkOutput("midrst_y", int'(y), 6);
    checkOutput("midrst_video_on", int'(videoOn), 0);
    checkOutput("midrst_frame_count", int'(frameCount), 0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("midrst_frame_start", int'(frameStart), 1);

    waitFor(0, 5, 500, "reach_y5");
    checkOutput("vsync_at_y5", int'(vsync), 0);

    for (int i = 0; i < 6000; i++) begin
      applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0));
    end

    // Continuous run to the frame counter wrap: 254*98+1 ticks gives count 255.
    applyStimulus(1'b1, 1'b1);
    repeat (49786) applyStimulus(1'b0, 1'b1);
    checkOutput("fc_255", int'(frameCount), 255);
    checkOutput("fc_255_frame_start", int'(frameStart), 1);
    repeat (196) applyStimulus(1'b0, 1'b1);
    checkOutput("fc_wrap", int'(frameCount), 0);
    checkOutput("fc_wrap_frame_start", int'(frameStart), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
